// File: rtl/load_store_unit_pkg.sv
// rv_pkg: shared RISC-V load/store constants and the LSU state encoding.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} lsu_state_e;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute request, data-memory bus and register-file write port.
interface load_store_unit_if;
  import rv_pkg::*;
  logic                  req_valid;
  logic                  req_ready;
  logic                  is_store;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       addr;
  logic [XLEN-1:0]       store_data;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_we;
  logic [XLEN-1:0]       mem_addr;
  logic [3:0]            mem_be;
  logic [XLEN-1:0]       mem_wdata;
  logic                  mem_rvalid;
  logic [XLEN-1:0]       mem_rdata;
  logic                  rf_write;
  logic [REG_ADDR_W-1:0] rf_w_addr;
  logic [XLEN-1:0]       rf_w_data;
  logic                  done;
  logic                  err_misalign;
  logic                  err_timeout;
  modport master (
    input  req_valid, is_store, funct3, addr, store_data, rd_addr, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rf_write, rf_w_addr, rf_w_data,
           done, err_misalign, err_timeout
  );
  modport slave (
    output req_valid, is_store, funct3, addr, store_data, rd_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rf_write, rf_w_addr, rf_w_data,
           done, err_misalign, err_timeout
  );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: byte enables/lane-replicated store data, load lane extraction, and legality checks.
module lsu_align import rv_pkg::*; (
  input  logic            is_store,
  input  logic [2:0]      st_f3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic            bad,
  input  logic [2:0]      ld_f3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data
);
  logic illegal;
  logic misaligned;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    illegal = is_store ? (st_f3 > F3_W) : (st_f3 == 3'b011 || st_f3[2:1] == 2'b11);
    misaligned = (st_f3[1:0] == 2'b01 && st_off[0]) || (st_f3[1:0] == 2'b10 && st_off != 2'b00);
    bad = illegal || misaligned;
    be = st_f3[1:0] == 2'b00 ? 4'b0001 << st_off :
         st_f3[1:0] == 2'b01 ? (st_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = st_f3[1:0] == 2'b00 ? {4{st_data[7:0]}} :
            st_f3[1:0] == 2'b01 ? {2{st_data[15:0]}} : st_data;
    b = rdata[{ld_off, 3'b000} +: 8];
    h = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ld_data = ld_f3 == F3_B  ? {{24{b[7]}}, b} :
              ld_f3 == F3_H  ? {{16{h[15]}}, h} :
              ld_f3 == F3_BU ? {24'd0, b} :
              ld_f3 == F3_HU ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store engine between execute and the data bus.
module load_store_unit import rv_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rstn,
  load_store_unit_if.master bus
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  lsu_state_e state_q, state_d;
  logic req_ready_q, req_ready_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rf_w_data_q, rf_w_data_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic rf_write_q, rf_write_d, done_q, done_d, err_mis_q, err_mis_d, err_to_q, err_to_d;
  logic [REG_ADDR_W-1:0] rf_w_addr_q, rf_w_addr_d, rd_q, rd_d;
  logic is_store_q, is_store_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] be;
  logic [XLEN-1:0] wdata, ld_data;
  logic bad, timeout;
  lsu_align u_align (
    .is_store(bus.is_store), .st_f3(bus.funct3), .st_off(bus.addr[1:0]), .st_data(bus.store_data),
    .be(be), .wdata(wdata), .bad(bad),
    .ld_f3(f3_q), .ld_off(off_q), .rdata(bus.mem_rdata), .ld_data(ld_data)
  );
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
  always_comb begin
    state_d = state_q;
    req_ready_d = req_ready_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_be_d = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rf_write_d = 1'b0;
    rf_w_addr_d = rf_w_addr_q;
    rf_w_data_d = rf_w_data_q;
    done_d = 1'b0;
    err_mis_d = 1'b0;
    err_to_d = 1'b0;
    is_store_d = is_store_q;
    f3_d = f3_q;
    off_d = off_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_ready_q && bus.req_valid) begin
          is_store_d = bus.is_store;
          f3_d = bus.funct3;
          off_d = bus.addr[1:0];
          rd_d = bus.rd_addr;
          cnt_d = '0;
          req_ready_d = 1'b0;
          if (bad) begin
            err_mis_d = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = REQ;
            mem_req_d = 1'b1;
            mem_we_d = bus.is_store;
            mem_addr_d = {bus.addr[31:2], 2'b00};
            mem_be_d = be;
            mem_wdata_d = wdata;
          end
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A response wins over a same-cycle timeout; a grant does not.
        if (state_q == WAIT && bus.mem_rvalid) begin
          state_d = WB;
          done_d = 1'b1;
          if (!is_store_q && rd_q != '0) begin
            rf_write_d = 1'b1;
            rf_w_addr_d = rd_q;
            rf_w_data_d = ld_data;
          end
        end else if (timeout) begin
          state_d = IDLE;
          mem_req_d = 1'b0;
          mem_we_d = 1'b0;
          err_to_d = 1'b1;
          done_d = 1'b1;
        end else if (state_q == REQ && bus.mem_gnt) begin
          state_d = WAIT;
          mem_req_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_ready_q <= 1'b1;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q <= '0;
      mem_wdata_q <= '0;
      rf_write_q <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
      done_q <= 1'b0;
      err_mis_q <= 1'b0;
      err_to_q <= 1'b0;
      is_store_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      req_ready_q <= req_ready_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rf_write_q <= rf_write_d;
      rf_w_addr_q <= rf_w_addr_d;
      rf_w_data_q <= rf_w_data_d;
      done_q <= done_d;
      err_mis_q <= err_mis_d;
      err_to_q <= err_to_d;
      is_store_q <= is_store_d;
      f3_q <= f3_d;
      off_q <= off_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.req_ready = req_ready_q;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_be = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rf_write = rf_write_q;
  assign bus.rf_w_addr = rf_w_addr_q;
  assign bus.rf_w_data = rf_w_data_q;
  assign bus.done = done_q;
  assign bus.err_misalign = err_mis_q;
  assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store sequence with a completion scoreboard and a simple bus responder.
module tb_load_store_unit;
  import rv_pkg::*;
  typedef struct {
    logic        rfw;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        mis;
    logic        to;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  load_store_unit_if bus();
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int req_cycles = 0;
  exp_t sb[$];
  int gnt_delay = 0;
  logic rv_en = 1'b1;
  logic force_rv = 1'b0;
  logic [31:0] rd_v = '0, exp_addr = '0, exp_wd = '0;
  logic [3:0] exp_be = '0;
  logic exp_we = 1'b0;
  localparam logic [111:0] RST_VEC = {7'b1000000, 105'd0};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [111:0] out_vec();
    return {bus.req_ready, bus.mem_req, bus.mem_we, bus.rf_write, bus.done, bus.err_misalign,
            bus.err_timeout, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.rf_w_addr, bus.rf_w_data};
  endfunction
  // Bus responder: grants after gnt_delay request cycles, answers one cycle after grant.
  initial begin
    int phase = 0;
    int cnt = 0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = force_rv;
      if (force_rv) bus.mem_rdata = rd_v;
      if (bus.mem_req) req_cycles++;
      if (!rstn) begin
        phase = 0;
        cnt = 0;
      end else if (phase == 0 && bus.mem_req) begin
        if (cnt == gnt_delay) begin
          bus.mem_gnt = 1'b1;
          phase = 1;
          cnt = 0;
          chk("bus_addr", bus.mem_addr, exp_addr);
          chk("bus_be", bus.mem_be, exp_be);
          chk("bus_we", bus.mem_we, exp_we);
          if (exp_we) chk("bus_wdata", bus.mem_wdata, exp_wd);
        end else cnt++;
      end else if (phase == 1) begin
        phase = 0;
        if (rv_en) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = rd_v;
        end
      end
    end
  end
  // Completion monitor: every done/err/rf_write pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && (bus.done || bus.rf_write || bus.err_misalign || bus.err_timeout)) begin
        if (sb.size() == 0) chk("unexpected_done", {bus.done, bus.rf_write}, 0);
        else begin
          e = sb.pop_front();
          chk("done", bus.done, 1);
          chk("rf_write", bus.rf_write, e.rfw);
          if (e.rfw) begin
            chk("rf_w_addr", bus.rf_w_addr, e.ra);
            chk("rf_w_data", bus.rf_w_data, e.rd);
          end
          chk("err_misalign", bus.err_misalign, e.mis);
          chk("err_timeout", bus.err_timeout, e.to);
          chk("latency", cyc, e.cyc);
        end
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", bus.req_ready, 1);
  endtask
  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd);
    bus.req_valid = 1'b1;
    bus.is_store = st;
    bus.funct3 = f3;
    bus.addr = a;
    bus.store_data = sd;
    bus.rd_addr = rd;
  endtask
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rd, input logic [31:0] rdat, input int gd, input logic bad,
                       input logic to, input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erf);
    exp_t e;
    int n = 0;
    wait_ready();
    gnt_delay = gd;
    rv_en = !to;
    rd_v = rdat;
    exp_we = st;
    exp_addr = {a[31:2], 2'b00};
    exp_be = ebe;
    exp_wd = ewd;
    drive(st, f3, a, sd, rd);
    @(posedge clk);
    #1;
    e.rfw = !st && !bad && !to && rd != 5'd0;
    e.ra = rd;
    e.rd = erf;
    e.mis = bad;
    e.to = to;
    e.cyc = cyc + (bad ? 0 : to ? 4 : 2 + gd);
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("complete_timeout", sb.size(), 0);
  endtask
  initial begin
    int r0;
    bus.req_valid = 1'b0;
    bus.is_store = 1'b0;
    bus.funct3 = '0;
    bus.addr = '0;
    bus.store_data = '0;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), RST_VEC);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_outputs", out_vec(), RST_VEC);
    issue(0, F3_W,  32'h100, 0, 5'd5, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 0, 32'hDEADBEEF);
    issue(0, F3_B,  32'h103, 0, 5'd6, 32'h80FF7F00, 0, 0, 0, 4'b1000, 0, 32'hFFFFFF80);
    issue(0, F3_BU, 32'h103, 0, 5'd6, 32'h80FF7F00, 0, 0, 0, 4'b1000, 0, 32'h00000080);
    issue(1, F3_H,  32'h202, 32'h1234ABCD, 5'd3, 0, 0, 0, 0, 4'b1100, 32'hABCDABCD, 0);
    issue(0, F3_H,  32'h102, 0, 5'd7, 32'h80FF7F00, 1, 0, 0, 4'b1100, 0, 32'hFFFF80FF);
    issue(0, F3_HU, 32'h100, 0, 5'd8, 32'h80FF7F00, 0, 0, 0, 4'b0011, 0, 32'h00007F00);
    issue(1, F3_B,  32'h101, 32'h000000A5, 5'd0, 0, 1, 0, 0, 4'b0010, 32'hA5A5A5A5, 0);
    r0 = req_cycles;
    issue(0, F3_W,  32'h101, 0, 5'd4, 0, 0, 1, 0, 4'b1111, 0, 0);
    issue(0, 3'b011, 32'h100, 0, 5'd4, 0, 0, 1, 0, 4'b1111, 0, 0);
    issue(1, 3'b100, 32'h100, 32'h55, 5'd4, 0, 0, 1, 0, 4'b1111, 0, 0);
    chk("no_bus_on_error", req_cycles, r0);
    issue(0, F3_W,  32'h180, 0, 5'd0, 32'hCAFEF00D, 0, 0, 0, 4'b1111, 0, 0);
    issue(0, F3_W,  32'h400, 0, 5'd9, 32'h12345678, 0, 0, 1, 4'b1111, 0, 0);
    @(negedge clk);
    chk("ready_after_timeout", {bus.req_ready, bus.mem_req}, 2'b10);
    wait_ready();
    gnt_delay = 0;
    rv_en = 1'b0;
    rd_v = 32'h11111111;
    exp_we = 1'b0;
    exp_addr = 32'h300;
    exp_be = 4'b1111;
    drive(0, F3_W, 32'h300, 0, 5'd10);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("reset_in_wait", out_vec(), RST_VEC);
    @(negedge clk);
    rstn = 1'b1;
    force_rv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force_rv = 1'b0;
    chk("late_rvalid_ignored", {bus.rf_write, bus.mem_req, bus.done}, 0);
    repeat (2) @(negedge clk);
    chk("idle_after_reset", out_vec(), RST_VEC);
    rv_en = 1'b1;
    issue(0, F3_W,  32'h304, 0, 5'd11, 32'h0BADF00D, 0, 0, 0, 4'b1111, 0, 32'h0BADF00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
